rr_pkt_arbiter: RTL and testbench
=================================

RR_PKT_ARBITER -- requirements
Module: rr_pkt_arbiter

Interface
REQ-001 Parameter ARB_NUM, default 8: number of request ports (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 1024: maximum BUSY cycles per grant before forced release (>=2).
REQ-003 iClk  input  1  single clock; all state updates on posedge iClk.
REQ-004 iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 iReq  input  ARB_NUM  per-port request, already credit-masked by the weight gate.
REQ-006 iDone  input  1  one-cycle pulse from the read scheduler marking end of the current packet service.
REQ-007 oSel  output  ARB_NUM  one-hot selected port, held for the whole service (datapath mux control).
REQ-008 oSelIdx  output  $clog2(ARB_NUM)  binary index of oSel.
REQ-009 oSelVld  output  1  high while a selection is held (state BUSY).
REQ-010 oGnt  output  ARB_NUM  one-cycle one-hot commit pulse returned to the weight gate's iGnt; consumes exactly one credit per packet.
REQ-011 oTimeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 FSM states IDLE and BUSY; reset state IDLE.
REQ-013 IDLE with |iReq: winner = first set iReq bit at or above rrPtr, wrapping from ARB_NUM-1 to 0; register oSel/oSelIdx, enter BUSY next edge.
REQ-014 Latency: request sampled in IDLE at cycle N -> oSelVld=1 and oSel valid at cycle N+1.
REQ-015 IDLE with iReq==0: remain IDLE, oSel=0.
REQ-016 BUSY: oSel held constant regardless of iReq changes; request drop ignored.
REQ-017 BUSY with iDone=1: oGnt = oSel combinationally in that same cycle; next edge rrPtr <= oSelIdx+1 (mod ARB_NUM), oSel <= 0, state IDLE.
REQ-018 oGnt is 0 in every cycle except REQ-017's cycle; iDone in IDLE is ignored (no oGnt, no state change).
REQ-019 One mandatory IDLE cycle after every release, giving the weight gate one edge to decrement/refresh before re-arbitration.
REQ-020 Cycle counter cleared on entering BUSY and incremented each BUSY cycle; saturates at TIMEOUT-1.
REQ-021 BUSY, counter==TIMEOUT-1, iDone=0: oTimeout=1 that cycle, oGnt stays 0, rrPtr <= oSelIdx+1, state IDLE next edge.
REQ-022 iDone and timeout coincident: iDone wins (normal commit, oTimeout=0).
REQ-023 rrPtr is $clog2(ARB_NUM) bits, wraps naturally; reset value 0.

Reset
REQ-024 Asserting iRst_n low at any time, including mid-BUSY, forces state IDLE, rrPtr=0, counter=0, oSel=0, oSelIdx=0, oSelVld=0, oGnt=0, oTimeout=0 immediately, with no oGnt pulse for the aborted service.
REQ-025 First arbitration after deassertion occurs on the first edge with iRst_n high and |iReq.

Structure
REQ-026 Shared package holds ARB_NUM and TIMEOUT defaults and the state enum {IDLE, BUSY}.
REQ-027 One sub-module rr_pick (combinational rotate/priority-encode: iReq, rrPtr -> one-hot winner and index); all other logic in rr_pkt_arbiter.

Verification
REQ-028 Reset, iReq=8'hFF, iDone after 3 BUSY cycles, repeated -> oSelIdx sequence 0,1,2,...,7,0; one oGnt pulse per packet.
REQ-029 iReq=8'b1000_0100, rrPtr=3 -> oSelIdx=7; after iDone, rrPtr=0 -> next oSelIdx=2.
REQ-030 Grant to port 5, iReq[5] drops mid-BUSY -> oSel stays 8'h20 until iDone; oGnt=8'h20 in the iDone cycle only.
REQ-031 TIMEOUT=16, grant held, no iDone -> oTimeout pulse in BUSY cycle 16, oGnt never asserted, rrPtr=selected+1.
REQ-032 iRst_n low in BUSY -> all outputs 0 within the reset assertion, no oGnt; after release iReq=8'h01 -> oSel=8'h01 one cycle later.
REQ-033 Integrated with weight gate (weights all 2, iReq=8'hFF) -> every port served exactly twice per refresh round.

Source files
------------

// File: rtl/rr_pkt_arbiter_pkg.sv
// Shared defaults and FSM state type for the round-robin packet arbiter.
// Imported by rr_pick and rr_pkt_arbiter.
package rr_pkt_arbiter_pkg;
  localparam int ARB_NUM_DEF = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/rr_pkt_arbiter_pick.sv
// Round-robin pick: first set request at or above iPtr, wrapping to 0.
// Ports: iReq, iPtr in; oWin (one-hot), oIdx (binary) out.
module rr_pick
  import rr_pkt_arbiter_pkg::*;
#(
  parameter int ARB_NUM = ARB_NUM_DEF
) (
  input  logic [ARB_NUM-1:0]         iReq,
  input  logic [$clog2(ARB_NUM)-1:0] iPtr,
  output logic [ARB_NUM-1:0]         oWin,
  output logic [$clog2(ARB_NUM)-1:0] oIdx
);
  localparam int IW = $clog2(ARB_NUM);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    oWin  = '0;
    oIdx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < ARB_NUM; i++) begin
      // power-of-two ARB_NUM makes the add wrap for free
      idx = iPtr + IW'(i);
      if (!found && iReq[idx]) begin
        found     = 1'b1;
        oWin[idx] = 1'b1;
        oIdx      = idx;
      end
    end
  end
endmodule

// File: rtl/rr_pkt_arbiter.sv
// Round-robin packet arbiter: holds one port for a whole packet service.
// Ports: iClk, iRst_n, iReq, iDone in; oSel, oSelIdx, oSelVld, oGnt, oTimeout out.
module rr_pkt_arbiter
  import rr_pkt_arbiter_pkg::*;
#(
  parameter int ARB_NUM = ARB_NUM_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic [ARB_NUM-1:0]         iReq,
  input  logic                       iDone,
  output logic [ARB_NUM-1:0]         oSel,
  output logic [$clog2(ARB_NUM)-1:0] oSelIdx,
  output logic                       oSelVld,
  output logic [ARB_NUM-1:0]         oGnt,
  output logic                       oTimeout
);
  localparam int IW = $clog2(ARB_NUM);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ARB_NUM-1:0] sel_q, sel_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [ARB_NUM-1:0] win;
  logic [IW-1:0]      win_idx;
  logic               busy;
  logic               expire;

  rr_pick #(
    .ARB_NUM (ARB_NUM)
  ) u_pick (
    .iReq (iReq),
    .iPtr (ptr_q),
    .oWin (win),
    .oIdx (win_idx)
  );

  assign busy   = (state_q == BUSY);
  // iDone beats a coincident timeout
  assign expire = busy && !iDone && (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|iReq) begin
          sel_d   = win;
          idx_d   = win_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (iDone || expire) begin
          ptr_d   = idx_q + IW'(1);
          sel_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oSel     = sel_q;
  assign oSelIdx  = idx_q;
  assign oSelVld  = busy;
  // commit pulse is same-cycle with iDone
  assign oGnt     = (busy && iDone) ? sel_q : '0;
  assign oTimeout = expire;
endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Directed bench for rr_pkt_arbiter: vector table plus multi-cycle sequences.
// Inputs driven on negedge, outputs sampled 1ns later.
module tb_rr_pkt_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] sel;
  logic [2:0] sel_idx;
  logic       sel_vld;
  logic [7:0] gnt;
  logic       tmo;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_pkt_arbiter #(
    .ARB_NUM (8),
    .TIMEOUT (16)
  ) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iReq     (req),
    .iDone    (done),
    .oSel     (sel),
    .oSelIdx  (sel_idx),
    .oSelVld  (sel_vld),
    .oGnt     (gnt),
    .oTimeout (tmo)
  );

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] sel;
    logic [2:0] idx;
    logic       vld;
    logic [7:0] gnt;
    logic       tmo;
  } vec_t;

  vec_t vec[17];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_sel,
                         input logic [2:0] e_idx, input logic e_vld,
                         input logic [7:0] e_gnt, input logic e_tmo);
    chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
    chk({tag, ".idx"}, 32'(sel_idx), 32'(e_idx));
    chk({tag, ".vld"}, 32'(sel_vld), 32'(e_vld));
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".tmo"}, 32'(tmo), 32'(e_tmo));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    // {req, done, sel, idx, vld, gnt, tmo}; outputs before the edge
    vec[0]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    vec[1]  = '{8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    vec[2]  = '{8'h00, 1'b0, 8'h04, 3'd2, 1'b1, 8'h00, 1'b0};
    vec[3]  = '{8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 8'h04, 1'b0};
    vec[4]  = '{8'h84, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    vec[5]  = '{8'h84, 1'b1, 8'h80, 3'd7, 1'b1, 8'h80, 1'b0};
    vec[6]  = '{8'h84, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    vec[7]  = '{8'h00, 1'b1, 8'h04, 3'd2, 1'b1, 8'h04, 1'b0};
    vec[8]  = '{8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    vec[9]  = '{8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 8'h00, 1'b0};
    vec[10] = '{8'hFF, 1'b0, 8'h20, 3'd5, 1'b1, 8'h00, 1'b0};
    vec[11] = '{8'h00, 1'b1, 8'h20, 3'd5, 1'b1, 8'h20, 1'b0};
    vec[12] = '{8'h41, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    vec[13] = '{8'h41, 1'b1, 8'h40, 3'd6, 1'b1, 8'h40, 1'b0};
    vec[14] = '{8'h41, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
    vec[15] = '{8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01, 1'b0};
    vec[16] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};

    do_reset();
    for (int v = 0; v < 17; v++) begin
      @(negedge clk);
      req  = vec[v].req;
      done = vec[v].done;
      #1;
      chk_all($sformatf("vec%0d", v), vec[v].sel, vec[v].idx,
              vec[v].vld, vec[v].gnt, vec[v].tmo);
    end

    // all ports requesting, iDone on the third BUSY cycle
    do_reset();
    @(negedge clk);
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      done = 1'b0;
      #1;
      chk($sformatf("rr%0d.idx", k), 32'(sel_idx), 32'(k % 8));
      chk($sformatf("rr%0d.vld", k), 32'(sel_vld), 32'd1);
      chk($sformatf("rr%0d.gnt0", k), 32'(gnt), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d.gnt1", k), 32'(gnt), 32'd0);
      @(negedge clk);
      done = 1'b1;
      #1;
      chk($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(8'h01 << (k % 8)));
      @(negedge clk);
      done = 1'b0;
      #1;
      chk($sformatf("rr%0d.idle", k), 32'(sel_vld), 32'd0);
      chk($sformatf("rr%0d.gnt2", k), 32'(gnt), 32'd0);
    end

    // forced release after 16 BUSY cycles, no grant
    do_reset();
    @(negedge clk);
    req = 8'h08;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      req = 8'h00;
      #1;
      chk($sformatf("to_c%0d.tmo", c), 32'(tmo), 32'(c == 16));
      chk($sformatf("to_c%0d.gnt", c), 32'(gnt), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("to_idle.vld", 32'(sel_vld), 32'd0);
    chk("to_idle.tmo", 32'(tmo), 32'd0);
    req = 8'hFF;

    // pointer moved to 4; then iDone coincident with timeout
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      done = (c == 16);
      #1;
      if (c == 1)
        chk("co.idx", 32'(sel_idx), 32'd4);
      chk($sformatf("co_c%0d.tmo", c), 32'(tmo), 32'd0);
      chk($sformatf("co_c%0d.gnt", c), 32'(gnt),
          (c == 16) ? 32'h10 : 32'h0);
    end
    @(negedge clk);
    done = 1'b0;
    req  = 8'h00;
    #1;
    chk("co_idle.vld", 32'(sel_vld), 32'd0);

    // reset asserted mid-BUSY
    do_reset();
    @(negedge clk);
    req = 8'h40;
    @(negedge clk);
    #1;
    chk("mr.busy", 32'(sel), 32'h40);
    done  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all("mr.rst", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done  = 1'b0;
    req   = 8'h01;
    #1;
    chk("mr.pre.vld", 32'(sel_vld), 32'd0);
    @(negedge clk);
    #1;
    chk_all("mr.post", 8'h01, 3'd0, 1'b1, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
